muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, replacing the single-cycle combinational multiplier and its two ungated HI/LO registers in the MIPS datapath. It executes MULT, MULTU, DIV and DIVU iteratively (one bit per cycle) under a start/busy/done handshake. It also supports direct HI/LO writes (MTHI/MTLO) and exposes HI/LO to the MFHI/MFLO result mux.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; legal values 4..64
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request an operation; accepted only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start
- we_hi  in  1  MTHI: write wd into HI
- we_lo  in  1  MTLO: write wd into LO
- wd  in  WIDTH  direct write data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  out  1  pulses with done when a DIV/DIVU had b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op and the operand magnitudes. Signed ops use two's-complement absolute values; unsigned ops use the raw values.
  - Records the result sign(s) and the zero-divisor flag, clears the iteration counter, and goes to CALC.
- CALC: exactly WIDTH iterations, one per cycle.
  - Multiply: shift-add on magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring division, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
  - When the counter reaches WIDTH-1, goes to FIX.
- FIX: applies the sign correction, writes HI/LO, pulses done and returns to IDLE.
  - Multiply: the 2·WIDTH product is negated if the signs differ (MULT only). HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder. For DIV, the quotient is negative iff the operand signs differ, truncating toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (either op): HI = a as sampled, LO = all ones, div_by_zero=1 alongside done. Same latency as a normal divide.
  - DIV of the most negative value by -1: LO = most negative value, HI = 0 (natural WIDTH-bit wrap); no flag.
- HI/LO change only on a FIX write, on we_hi/we_lo while busy=0, or on reset.
- we_hi/we_lo while busy=1 are ignored; they are not queued.
- start while busy=1 is ignored; it is not queued.
- Simultaneous start and we_hi/we_lo in IDLE: the write takes effect, the operation is also accepted, and FIX later overwrites both HI and LO.
- Internal operand, accumulator and counter registers are not observable; their reset value is don't-care.

## Timing
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Takes effect immediately, including mid-CALC or mid-FIX. The in-flight operation is discarded and produces no done.
- start sampled at edge t:
  - busy=1 from after edge t through edge t+WIDTH+1.
  - hi/lo updated and done=1 after edge t+WIDTH+1 (registered outputs, no combinational path from inputs).
  - Latency is WIDTH+1 cycles: 33 for WIDTH=32.
- done and div_by_zero are high for exactly one cycle. busy is already 0 in that cycle.
- Back-to-back: a start in the done cycle is accepted, giving WIDTH+1 cycles per operation.
- operand, op and wd inputs need only be valid in the cycle they are sampled.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, WIDTH=32 -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then immediately (start in the done cycle) MULT 0 × 0x12345678 -> hi=0, lo=0, 33 cycles later.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 with done. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Mid-operation stimulus and reset:
  - During CALC, start with new operands plus we_hi=1, wd=0xAAAA -> both ignored; the original result lands on schedule.
  - In IDLE, we_lo=1, wd=0x55 -> lo=0x55 next cycle.
  - reset_n=0 mid-CALC -> hi=lo=0, busy=0 immediately, no done pulse. The next MULTU 3×4 gives lo=12.
- WIDTH=8 instance: MULT a=0x80 b=0x80 -> hi=0x40, lo=0x00 with done 9 cycles after start. DIV a=0x80 b=0xFF -> lo=0x80, hi=0x00.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done handshake, operands and HI/LO access for muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nx;
  logic               is_div;
  logic               sign_a, sign_b, zero_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, a_orig, fix_hi, fix_lo;

  logic accept;
  assign accept = (state == IDLE) && bus.start;

  always_comb begin
    neg_a_in = ~bus.op[0] & bus.a[WIDTH-1];
    neg_b_in = ~bus.op[0] & bus.b[WIDTH-1];
    mag_a_in = neg_a_in ? -bus.a : bus.a;
    mag_b_in = neg_b_in ? -bus.b : bus.b;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_rem_sh = acc[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rem_sh - {1'b0, mag_b};
    div_ge     = ~div_diff[WIDTH];
    if (is_div)
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quo    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    a_orig = sign_a ? -mag_a : mag_a;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = zero_b ? a_orig : rem;
      fix_lo = zero_b ? '1 : quo;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= bus.op[1];
      sign_a <= neg_a_in;
      sign_b <= neg_b_in;
      zero_b <= (bus.b == '0);
      mag_a  <= mag_a_in;
      mag_b  <= mag_b_in;
      acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a_in : mag_b_in)};
      cnt    <= '0;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
    end
  end

  // Direct writes are only honoured while idle; FIX always wins over them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      dbz_q  <= (state == FIX) && is_div && zero_b;
      if (state == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state == IDLE) begin
        if (bus.we_hi) hi_q <= bus.wd;
        if (bus.we_lo) lo_q <= bus.wd;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8)
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) if32 ();
  muldiv_unit_if #(.WIDTH(8))  if8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

  int checks = 0;
  int errors = 0;
  int lat, bsy, ndone;
  logic [31:0] hi_mid;
  logic [7:0]  hi_e;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where done is seen (or a timeout).
  task automatic do32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int disturb_at, output int lat_o, output int bsy_o,
                      output logic [31:0] hi_mid_o);
    if32.op = op; if32.a = a; if32.b = b; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0; if32.a = '0; if32.b = '0;
    lat_o = 0; bsy_o = 0; hi_mid_o = '0;
    while (!if32.done && lat_o < 60) begin
      if (if32.busy) bsy_o++;
      if (lat_o == disturb_at + 2) hi_mid_o = if32.hi;
      if (lat_o == disturb_at) begin
        if32.start = 1'b1; if32.op = 2'b11; if32.a = 32'd9; if32.b = 32'd3;
        if32.we_hi = 1'b1; if32.wd = 32'hAAAA;
      end else begin
        if32.start = 1'b0; if32.we_hi = 1'b0;
      end
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  task automatic do8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic whi, input logic [7:0] wdv, output int lat_o, output logic [7:0] hi_o);
    if8.op = op; if8.a = a; if8.b = b; if8.start = 1'b1; if8.we_hi = whi; if8.wd = wdv;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.we_hi = 1'b0; if8.a = '0; if8.b = '0;
    hi_o = if8.hi;
    lat_o = 0;
    while (!if8.done && lat_o < 30) begin
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  initial begin
    if32.start = 1'b0; if32.op = '0; if32.a = '0; if32.b = '0;
    if32.we_hi = 1'b0; if32.we_lo = 1'b0; if32.wd = '0;
    if8.start = 1'b0; if8.op = '0; if8.a = '0; if8.b = '0;
    if8.we_hi = 1'b0; if8.we_lo = 1'b0; if8.wd = '0;

    repeat (2) @(posedge clk); #1;
    chk32("rst_hi", if32.hi, 32'h0);
    chk32("rst_lo", if32.lo, 32'h0);
    chk1("rst_busy", if32.busy, 1'b0);
    chk1("rst_done", if32.done, 1'b0);
    chk1("rst_dbz", if32.div_by_zero, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -10, lat, bsy, hi_mid);
    chk32("multu_lat", lat, 33);
    chk32("multu_busy_cycles", bsy, 33);
    chk1("multu_busy_in_done", if32.busy, 1'b0);
    chk32("multu_hi", if32.hi, 32'hFFFFFFFE);
    chk32("multu_lo", if32.lo, 32'h00000001);
    @(posedge clk); #1;
    chk1("done_one_cycle", if32.done, 1'b0);

    do32(2'b00, 32'hFFFFFFFD, 32'd7, -10, lat, bsy, hi_mid);
    chk32("mult_neg_hi", if32.hi, 32'hFFFFFFFF);
    chk32("mult_neg_lo", if32.lo, 32'hFFFFFFEB);
    do32(2'b00, 32'h0, 32'h12345678, -10, lat, bsy, hi_mid);
    chk32("b2b_lat", lat, 33);
    chk32("b2b_hi", if32.hi, 32'h0);
    chk32("b2b_lo", if32.lo, 32'h0);

    do32(2'b10, 32'hFFFFFFF9, 32'd2, -10, lat, bsy, hi_mid);
    chk32("div_neg_lo", if32.lo, 32'hFFFFFFFD);
    chk32("div_neg_hi", if32.hi, 32'hFFFFFFFF);
    do32(2'b11, 32'd100, 32'd7, -10, lat, bsy, hi_mid);
    chk32("divu_lo", if32.lo, 32'd14);
    chk32("divu_hi", if32.hi, 32'd2);

    do32(2'b11, 32'd5, 32'd0, -10, lat, bsy, hi_mid);
    chk32("divu0_lat", lat, 33);
    chk32("divu0_hi", if32.hi, 32'd5);
    chk32("divu0_lo", if32.lo, 32'hFFFFFFFF);
    chk1("divu0_flag", if32.div_by_zero, 1'b1);
    @(posedge clk); #1;
    chk1("divu0_flag_one_cycle", if32.div_by_zero, 1'b0);
    do32(2'b10, 32'h80000000, 32'hFFFFFFFF, -10, lat, bsy, hi_mid);
    chk32("div_ovf_lo", if32.lo, 32'h80000000);
    chk32("div_ovf_hi", if32.hi, 32'h0);
    chk1("div_ovf_flag", if32.div_by_zero, 1'b0);
    do32(2'b10, 32'hFFFFFFF9, 32'd0, -10, lat, bsy, hi_mid);
    chk32("div0_signed_hi", if32.hi, 32'hFFFFFFF9);
    chk32("div0_signed_lo", if32.lo, 32'hFFFFFFFF);
    chk1("div0_signed_flag", if32.div_by_zero, 1'b1);

    do32(2'b01, 32'd6, 32'd7, 5, lat, bsy, hi_mid);
    chk32("ignored_we_hi_mid", hi_mid, 32'hFFFFFFF9);
    chk32("ignored_lat", lat, 33);
    chk32("ignored_hi", if32.hi, 32'h0);
    chk32("ignored_lo", if32.lo, 32'd42);
    @(posedge clk); #1;
    chk1("ignored_start_not_queued", if32.busy, 1'b0);

    if32.we_lo = 1'b1; if32.wd = 32'h55;
    @(posedge clk); #1;
    if32.we_lo = 1'b0; if32.wd = '0;
    chk32("mtlo_lo", if32.lo, 32'h55);
    if32.we_hi = 1'b1; if32.wd = 32'h66;
    @(posedge clk); #1;
    if32.we_hi = 1'b0; if32.wd = '0;
    chk32("mthi_hi", if32.hi, 32'h66);
    chk32("mthi_lo_kept", if32.lo, 32'h55);

    if32.op = 2'b01; if32.a = 32'hFFFF; if32.b = 32'hFFFF; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk1("midreset_busy", if32.busy, 1'b0);
    chk32("midreset_hi", if32.hi, 32'h0);
    chk32("midreset_lo", if32.lo, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.done) ndone++;
    end
    chk32("midreset_no_done", ndone, 0);
    do32(2'b01, 32'd3, 32'd4, -10, lat, bsy, hi_mid);
    chk32("post_reset_lo", if32.lo, 32'd12);
    chk32("post_reset_hi", if32.hi, 32'd0);

    do8(2'b00, 8'h80, 8'h80, 1'b0, 8'h00, lat, hi_e);
    chk32("w8_mult_lat", lat, 9);
    chk8("w8_mult_hi", if8.hi, 8'h40);
    chk8("w8_mult_lo", if8.lo, 8'h00);
    do8(2'b10, 8'h80, 8'hFF, 1'b0, 8'h00, lat, hi_e);
    chk8("w8_div_lo", if8.lo, 8'h80);
    chk8("w8_div_hi", if8.hi, 8'h00);
    chk1("w8_div_flag", if8.div_by_zero, 1'b0);
    do8(2'b01, 8'd3, 8'd5, 1'b1, 8'h77, lat, hi_e);
    chk8("w8_start_with_write_hi", hi_e, 8'h77);
    chk8("w8_start_with_write_final_hi", if8.hi, 8'h00);
    chk8("w8_start_with_write_final_lo", if8.lo, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
